membus_arbiter: RTL and testbench

- Sequences the single-ported data RAM and shares it between two requesters: the MEM-stage data port (M0) and the instruction-fetch port (M1).
- Owns all RAM control signals: chip enable, write enable, byte-lane select, address and write data. Each requester sees a req/ack handshake and a stall indication.
- Sits between the CPU core's memory-facing stages and the RAM. The core freezes its pipeline while either stall is high.

---
 rtl/membus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_membus_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/membus_arbiter.sv
// membus_arbiter: shares one single-ported data RAM between the MEM-stage
// data port (M0) and the instruction-fetch port (M1). M0 normally wins, but a
// burst counter forces an M1 grant after MAX_M0_BURST back-to-back M0 grants
// while M1 is waiting. Each access is IDLE/RESP -> ACCESS (WAIT_CYCLES+1) -> RESP.
module membus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int WAIT_CYCLES  = 0,
    parameter int MAX_M0_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [3:0]        m0_sel,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_stall,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [3:0]        m1_sel,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_stall,

    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [3:0]        ram_sel,
    input  logic [DATA_W-1:0] ram_rdata
);

    // RAM chip-enable polarity in one place so a different macro is a one-line change.
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);
    localparam logic [3:0] BURST_MAX = 4'(MAX_M0_BURST);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;     // 0 = M0, 1 = M1
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          sel_q, sel_d;
    logic [3:0]          burst_q, burst_d;
    logic [2:0]          wait_q, wait_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

    logic                arb_en;
    logic                force_m1;
    logic                grant_m0;
    logic                grant_m1;

    // Grant decision: M0 priority unless M1 has waited through a full M0 burst.
    always_comb begin
        arb_en   = (state_q == S_IDLE) || (state_q == S_RESP);
        force_m1 = m1_req && (burst_q == BURST_MAX);
        grant_m0 = arb_en && m0_req && !force_m1;
        grant_m1 = arb_en && m1_req && (force_m1 || !m0_req);
    end

    // Next state, payload capture, wait counting and read-data capture.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        wait_d     = wait_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;

        case (state_q)
            S_IDLE, S_RESP: begin
                wait_d = 3'd0;
                if (grant_m0) begin
                    owner_d = 1'b0;
                    we_d    = m0_we;
                    addr_d  = m0_addr;
                    wdata_d = m0_wdata;
                    sel_d   = m0_sel;
                    state_d = S_ACCESS;
                end else if (grant_m1) begin
                    owner_d = 1'b1;
                    we_d    = m1_we;
                    addr_d  = m1_addr;
                    wdata_d = m1_wdata;
                    sel_d   = m1_sel;
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = 3'd0;
                    state_d = S_RESP;
                    if (!we_q) begin
                        if (owner_q) begin
                            m1_rdata_d = ram_rdata;
                        end else begin
                            m0_rdata_d = ram_rdata;
                        end
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                wait_d  = 3'd0;
            end
        endcase
    end

    // Burst counter: counts M0 grants made while M1 waits, saturating at the limit.
    always_comb begin
        burst_d = burst_q;
        if (!m1_req || grant_m1) begin
            burst_d = 4'd0;
        end else if (grant_m0 && (burst_q != BURST_MAX)) begin
            burst_d = burst_q + 4'd1;
        end
    end

    // State and payload registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= 4'd0;
            burst_q    <= 4'd0;
            wait_q     <= 3'd0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            burst_q    <= burst_d;
            wait_q     <= wait_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // RAM controls decode straight from the state register, so reset drops ce at once.
    always_comb begin
        ram_ce    = (state_q == S_ACCESS) ? CHIP_ENABLE : CHIP_DISABLE;
        ram_we    = (state_q == S_ACCESS) && we_q;
        ram_sel   = (state_q == S_ACCESS) ? (we_q ? sel_q : 4'hF) : 4'h0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
    end

    // Handshake outputs: ack for the owner during RESP, stall until that ack.
    always_comb begin
        m0_ack   = (state_q == S_RESP) && !owner_q;
        m1_ack   = (state_q == S_RESP) &&  owner_q;
        m0_rdata = m0_rdata_q;
        m1_rdata = m1_rdata_q;
        m0_stall = m0_req & ~m0_ack;
        m1_stall = m1_req & ~m1_ack;
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: one instance with WAIT_CYCLES=0 and one
// with WAIT_CYCLES=3, each attached to its own small behavioural RAM.
module tb_membus_arbiter;

    logic        clk;
    logic        rst_n;

    // Instance with zero wait states.
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_ack, m1_ack, m0_stall, m1_stall;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;

    // Instance with three wait states (reads only).
    logic        w_m0_req, w_m1_req;
    logic [31:0] w_addr;
    logic        w_m0_ack, w_m1_ack, w_m0_stall, w_m1_stall;
    logic [31:0] w_m0_rdata, w_m1_rdata;
    logic        w_ram_ce, w_ram_we;
    logic [31:0] w_ram_addr, w_ram_wdata, w_ram_rdata;
    logic [3:0]  w_ram_sel;

    logic [31:0] mem0 [0:255];
    logic [31:0] mem3 [0:255];

    int checks;
    int failures;

    membus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0), .MAX_M0_BURST(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_sel(m0_sel),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_stall(m0_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_stall(m1_stall),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_sel(ram_sel), .ram_rdata(ram_rdata)
    );

    membus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3), .MAX_M0_BURST(4)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(w_m0_req), .m0_we(1'b0), .m0_addr(w_addr), .m0_wdata(32'h0), .m0_sel(4'h0),
        .m0_ack(w_m0_ack), .m0_rdata(w_m0_rdata), .m0_stall(w_m0_stall),
        .m1_req(w_m1_req), .m1_we(1'b0), .m1_addr(w_addr), .m1_wdata(32'h0), .m1_sel(4'h0),
        .m1_ack(w_m1_ack), .m1_rdata(w_m1_rdata), .m1_stall(w_m1_stall),
        .ram_ce(w_ram_ce), .ram_we(w_ram_we), .ram_addr(w_ram_addr), .ram_wdata(w_ram_wdata),
        .ram_sel(w_ram_sel), .ram_rdata(w_ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_rdata   = mem0[ram_addr[9:2]];
    assign w_ram_rdata = mem3[w_ram_addr[9:2]];

    // RAM models: preload, then byte-lane writes on the rising edge.
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'h0;
            mem3[i] = 32'h0;
        end
        mem0[64] = 32'hDEADBEEF;
        mem3[64] = 32'hCAFEF00D;
        forever begin
            @(posedge clk);
            if (ram_ce && ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_sel[b]) mem0[ram_addr[9:2]][8*b +: 8] = ram_wdata[8*b +: 8];
                end
            end
            if (w_ram_ce && w_ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_ram_sel[b]) mem3[w_ram_addr[9:2]][8*b +: 8] = w_ram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Runs one transaction on dut0 from a negedge in IDLE and measures it.
    task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel,
                          output int ack_cyc, output int ce_cyc, output logic [31:0] rd,
                          output logic [3:0] sel_seen, output logic [31:0] addr_seen,
                          output bit other_ack);
        if (!port) begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_sel = sel;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_sel = sel;
        end
        ack_cyc = -1; ce_cyc = 0; rd = 32'h0; sel_seen = 4'h0; addr_seen = 32'h0; other_ack = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ram_ce) begin
                ce_cyc++;
                sel_seen  = ram_sel;
                addr_seen = ram_addr;
            end
            if (port ? m0_ack : m1_ack) other_ack = 1'b1;
            if (port ? m1_ack : m0_ack) begin
                ack_cyc = c;
                rd = port ? m1_rdata : m0_rdata;
                break;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (ram_ce !== 1'b0) begin failures++; $display("FAIL reset_ce got %b exp 0", ram_ce); end
        checks++; if (ram_we !== 1'b0 || ram_sel !== 4'h0) begin failures++; $display("FAIL reset_we_sel got %b/%h exp 0/0", ram_we, ram_sel); end
        checks++; if (ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin failures++; $display("FAIL reset_addr_wdata got %h/%h exp 0/0", ram_addr, ram_wdata); end
        checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got %b%b exp 00", m0_ack, m1_ack); end
        checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got %h/%h exp 0/0", m0_rdata, m1_rdata); end
        checks++; if (w_ram_ce !== 1'b0) begin failures++; $display("FAIL reset_w_ce got %b exp 0", w_ram_ce); end
    endtask

    task automatic test_single_read();
        int ack_c, ce_c; logic [31:0] rd, a; logic [3:0] s; bit oth;
        do_txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, ack_c, ce_c, rd, s, a, oth);
        checks++; if (ack_c !== 2) begin failures++; $display("FAIL read_ack_cycle got %0d exp 2", ack_c); end
        checks++; if (ce_c !== 1) begin failures++; $display("FAIL read_ce_cycles got %0d exp 1", ce_c); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL read_rdata got %h exp deadbeef", rd); end
        checks++; if (s !== 4'hF || a !== 32'h100) begin failures++; $display("FAIL read_ram_sel_addr got %h/%h exp f/100", s, a); end
        checks++; if (m0_ack !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL read_after_ack got %b/%h exp 0/deadbeef", m0_ack, m0_rdata); end
    endtask

    task automatic test_write_readback();
        int ack_c, ce_c; logic [31:0] rd, a; logic [3:0] s; bit oth;
        do_txn(1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF, ack_c, ce_c, rd, s, a, oth);
        checks++; if (ack_c !== 2 || oth !== 1'b0) begin failures++; $display("FAIL m1_write_ack got %0d/%b exp 2/0", ack_c, oth); end
        checks++; if (mem0[16] !== 32'h12345678) begin failures++; $display("FAIL m1_write_mem got %h exp 12345678", mem0[16]); end
        do_txn(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, ack_c, ce_c, rd, s, a, oth);
        checks++; if (rd !== 32'h12345678 || oth !== 1'b0) begin failures++; $display("FAIL m1_readback got %h/%b exp 12345678/0", rd, oth); end
        checks++; if (m0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL m0_rdata_kept got %h exp deadbeef", m0_rdata); end
        // partial write: lanes 0 and 2 only
        do_txn(1'b0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, ack_c, ce_c, rd, s, a, oth);
        checks++; if (s !== 4'b0101 || mem0[16] !== 32'h12BB56DD) begin failures++; $display("FAIL byte_lane_write got sel %h mem %h exp 5/12bb56dd", s, mem0[16]); end
        checks++; if (m0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL write_keeps_rdata got %h exp deadbeef", m0_rdata); end
    endtask

    task automatic test_simultaneous();
        int a0, a1, bad_stall;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40;
        a0 = -1; a1 = -1; bad_stall = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (m1_ack) begin
                a1 = c;
                m1_req = 1'b0;
                break;
            end
            if (m1_stall !== 1'b1) bad_stall++;
            if (m0_ack) begin
                a0 = c;
                m0_req = 1'b0;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        checks++; if (a0 !== 2) begin failures++; $display("FAIL simul_m0_ack got %0d exp 2", a0); end
        checks++; if (a1 !== 4) begin failures++; $display("FAIL simul_m1_ack got %0d exp 4", a1); end
        checks++; if (bad_stall !== 0) begin failures++; $display("FAIL simul_m1_stall got %0d low cycles exp 0", bad_stall); end
        checks++; if (m1_rdata !== 32'h12BB56DD) begin failures++; $display("FAIL simul_m1_rdata got %h exp 12bb56dd", m1_rdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int order [0:5];
        int ackc  [0:5];
        int exp_order [0:5];
        int n;
        exp_order = '{0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin order[i] = -1; ackc[i] = -1; end
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40;
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (m0_ack && n < 6) begin order[n] = 0; ackc[n] = c; n++; end
            if (m1_ack && n < 6) begin order[n] = 1; ackc[n] = c; n++; end
            if (n == 6) break;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        checks++; if (n !== 6) begin failures++; $display("FAIL burst_grants got %0d exp 6", n); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (order[i] !== exp_order[i] || ackc[i] !== 2 * (i + 1)) begin
                failures++;
                $display("FAIL burst_grant_%0d got M%0d@%0d exp M%0d@%0d", i, order[i], ackc[i], exp_order[i], 2 * (i + 1));
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        int ack_c, ce_c, addr_bad;
        w_m0_req = 1'b1; w_addr = 32'h100;
        ack_c = -1; ce_c = 0; addr_bad = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (w_ram_ce) begin
                ce_c++;
                if (w_ram_addr !== 32'h100 || w_ram_sel !== 4'hF) addr_bad++;
            end
            if (w_m0_ack) begin ack_c = c; break; end
        end
        w_m0_req = 1'b0;
        checks++; if (ce_c !== 4) begin failures++; $display("FAIL wait_ce_cycles got %0d exp 4", ce_c); end
        checks++; if (ack_c !== 5) begin failures++; $display("FAIL wait_ack_cycle got %0d exp 5", ack_c); end
        checks++; if (addr_bad !== 0) begin failures++; $display("FAIL wait_addr_stable got %0d bad cycles exp 0", addr_bad); end
        checks++; if (w_m0_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL wait_rdata got %h exp cafef00d", w_m0_rdata); end
        @(negedge clk);
        checks++; if (w_m0_ack !== 1'b0 || w_ram_ce !== 1'b0) begin failures++; $display("FAIL wait_ack_pulse got %b/%b exp 0/0", w_m0_ack, w_ram_ce); end
    endtask

    task automatic test_reset_mid_access();
        int ack_seen, ce_seen, ack_c, ce_c;
        w_m0_req = 1'b1; w_addr = 32'h100;
        @(negedge clk);
        checks++; if (w_ram_ce !== 1'b1) begin failures++; $display("FAIL midrst_access1_ce got %b exp 1", w_ram_ce); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (w_ram_ce !== 1'b0) begin failures++; $display("FAIL midrst_async_ce got %b exp 0", w_ram_ce); end
        @(negedge clk);
        w_m0_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ack_seen = 0; ce_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (w_m0_ack || w_m1_ack) ack_seen++;
            if (w_ram_ce) ce_seen++;
        end
        checks++; if (ack_seen !== 0 || ce_seen !== 0) begin failures++; $display("FAIL midrst_no_ack got ack %0d ce %0d exp 0/0", ack_seen, ce_seen); end
        w_m1_req = 1'b1; w_addr = 32'h100;
        ack_c = -1; ce_c = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (w_ram_ce) ce_c++;
            if (w_m1_ack) begin ack_c = c; break; end
        end
        w_m1_req = 1'b0;
        checks++; if (ack_c !== 5 || ce_c !== 4) begin failures++; $display("FAIL midrst_m1_txn got ack %0d ce %0d exp 5/4", ack_c, ce_c); end
        checks++; if (w_m1_rdata !== 32'hCAFEF00D || w_m0_rdata !== 32'h0) begin failures++; $display("FAIL midrst_rdata got %h/%h exp cafef00d/0", w_m1_rdata, w_m0_rdata); end
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_sel = 4'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_sel = 4'h0;
        w_m0_req = 1'b0; w_m1_req = 1'b0; w_addr = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_single_read();
        test_write_readback();
        test_simultaneous();
        test_back_to_back();
        test_wait_states();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
